// File: rtl/sha256_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sha256_arb
//
// Round-robin arbiter that shares one SHA-256 core among NREQ requesters.
// A job moves through four phases:
//   IDLE  - pick the next requester (round robin from rr_ptr) and latch its
//           context.
//   ISSUE - present the latched context to the core until it is accepted.
//   BUSY  - wait for the digest, bounded by a TIMEOUT-cycle watchdog.
//   DONE  - hold the digest toward the requesters until res_rdy.
//
// Parameters
//   NREQ    number of requesters (2..8)
//   CTX_W   flattened context width per requester
//   TIMEOUT maximum number of BUSY cycles before the job is abandoned
//   IDW     requester index width, $clog2(NREQ)
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   req_vld        per-requester job request valid
//   req_rdy        per-requester job accept (one-hot or zero, IDLE only)
//   req_ctx        per-requester context, slice i = [i*CTX_W +: CTX_W]
//   core_ctx_vld   context valid toward the core
//   core_ctx_rdy   core ready to take the context
//   core_ctx       registered context driven to the core
//   core_hash_vld  core digest valid (only observed in BUSY)
//   core_hash      core digest
//   res_vld        result valid toward the requesters
//   res_rdy        result accept
//   res_id         index of the requester owning res_hash
//   res_hash       registered digest
//   grant_id       requester currently owning the core
//   busy           high in every state except IDLE
//   jobs_done      completed-job count, wraps at 16 bits
//   timeout_err    one-cycle pulse on the BUSY cycle where the job times out
// -----------------------------------------------------------------------------
module sha256_arb #(
    parameter int  NREQ    = 4,
    parameter int  CTX_W   = 1024,
    parameter int  TIMEOUT = 4096,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [NREQ-1:0]       req_vld,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*CTX_W-1:0] req_ctx,

    output logic                  core_ctx_vld,
    input  logic                  core_ctx_rdy,
    output logic [CTX_W-1:0]      core_ctx,
    input  logic                  core_hash_vld,
    input  logic [255:0]          core_hash,

    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [IDW-1:0]        res_id,
    output logic [255:0]          res_hash,

    output logic [IDW-1:0]        grant_id,
    output logic                  busy,
    output logic [15:0]           jobs_done,
    output logic                  timeout_err
);

    // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   tmo_cnt;

    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  rr_nx;
    logic [CTX_W-1:0] sel_ctx;
    logic            grant;
    logic            tmo_hit;

    // -------------------------------------------------------------------------
    // Round-robin pick.
    // Scanning downward lets the lowest matching index win. Two candidates are
    // tracked: the lowest request at or above rr_ptr (preferred) and the
    // lowest request overall (used when the search has to wrap).
    // -------------------------------------------------------------------------
    logic            hi_vld;
    logic [IDW-1:0]  hi_id;
    logic [IDW-1:0]  lo_id;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        hi_vld   = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        pick_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                if (IDW'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_id  = IDW'(i);
                end
                pick_vld = 1'b1;
                lo_id    = IDW'(i);
            end
        end
        pick_id = hi_vld ? hi_id : lo_id;
    end

    // Pointer advances to the slot after the winner, wrapping at NREQ (which
    // need not be a power of two).
    assign rr_nx = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + IDW'(1);

    // Context slice of the winner.
    always_comb begin
        sel_ctx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) begin
                sel_ctx = req_ctx[i*CTX_W +: CTX_W];
            end
        end
    end

    // The accept depends only on state, rr_ptr and req_vld: nothing from the
    // core or result side reaches req_rdy. It is gated by rst so a request is
    // never acknowledged on a cycle whose grant the reset discards.
    assign grant   = (state == S_IDLE) && pick_vld && !rst;
    assign req_rdy = grant ? (NREQ'(1) << pick_id) : '0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (pick_vld)      state_nx = S_ISSUE;
            S_ISSUE: if (core_ctx_rdy)  state_nx = S_BUSY;
            // A digest arriving on the timeout cycle still completes the job.
            S_BUSY:  if (core_hash_vld) state_nx = S_DONE;
                     else if (tmo_hit)  state_nx = S_IDLE;
            S_DONE:  if (res_rdy)       state_nx = S_IDLE;
            default:                    state_nx = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the wide context and digest registers are reset as well;
            // they are visible outputs and must not leak data across a reset.
            state     <= S_IDLE;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            core_ctx  <= '0;
            grant_id  <= '0;
            res_vld   <= 1'b0;
            res_id    <= '0;
            res_hash  <= '0;
            jobs_done <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        core_ctx <= sel_ctx;
                        grant_id <= pick_id;
                        rr_ptr   <= rr_nx;
                    end
                end
                S_ISSUE: begin
                    if (core_ctx_rdy) begin
                        tmo_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    if (core_hash_vld) begin
                        res_hash <= core_hash;
                        res_id   <= grant_id;
                        res_vld  <= 1'b1;
                    end else if (!tmo_hit) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (res_rdy) begin
                        res_vld   <= 1'b0;
                        jobs_done <= jobs_done + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs
    // -------------------------------------------------------------------------
    assign core_ctx_vld = (state == S_ISSUE);
    assign busy         = (state != S_IDLE);
    assign timeout_err  = (state == S_BUSY) && tmo_hit && !core_hash_vld && !rst;

endmodule

// File: tb/tb_sha256_arb.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sha256_arb
//
// Self-checking bench for sha256_arb. Jobs are driven phase by phase (grant,
// busy, done) with randomized contexts, digests, latencies and backpressure;
// inputs the arbiter must ignore are toggled at random. Expected grants come
// from a round-robin scan of the request vector, and expected results from
// the values the bench itself generated.
// -----------------------------------------------------------------------------
module tb_sha256_arb;

    localparam int NREQ    = 4;
    localparam int CTX_W   = 128;
    localparam int TIMEOUT = 16;
    localparam int IDW     = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_vld;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*CTX_W-1:0] req_ctx;
    logic                  core_ctx_vld;
    logic                  core_ctx_rdy;
    logic [CTX_W-1:0]      core_ctx;
    logic                  core_hash_vld;
    logic [255:0]          core_hash;
    logic                  res_vld;
    logic                  res_rdy;
    logic [IDW-1:0]        res_id;
    logic [255:0]          res_hash;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [15:0]           jobs_done;
    logic                  timeout_err;

    sha256_arb #(
        .NREQ    (NREQ),
        .CTX_W   (CTX_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_ctx       (req_ctx),
        .core_ctx_vld  (core_ctx_vld),
        .core_ctx_rdy  (core_ctx_rdy),
        .core_ctx      (core_ctx),
        .core_hash_vld (core_hash_vld),
        .core_hash     (core_hash),
        .res_vld       (res_vld),
        .res_rdy       (res_rdy),
        .res_id        (res_id),
        .res_hash      (res_hash),
        .grant_id      (grant_id),
        .busy          (busy),
        .jobs_done     (jobs_done),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: round-robin pointer and completed-job count.
    int m_ptr  = 0;
    int m_jobs = 0;

    logic [CTX_W-1:0] ctx_a [NREQ];

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled a further
    // 1 ns later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requesting index found scanning upward from ptr with wrap.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [255:0] rand_256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic randomize_ctx();
        for (int i = 0; i < NREQ; i++) begin
            for (int w = 0; w < CTX_W / 32; w++) ctx_a[i][w*32 +: 32] = $urandom;
            req_ctx[i*CTX_W +: CTX_W] = ctx_a[i];
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_req_rdy"},     req_rdy, 0);
        check({pfx, "_ctx_vld"},     core_ctx_vld, 0);
        check({pfx, "_core_ctx"},    core_ctx, 0);
        check({pfx, "_res_vld"},     res_vld, 0);
        check({pfx, "_res_id"},      res_id, 0);
        check({pfx, "_res_hash"},    res_hash, 0);
        check({pfx, "_grant_id"},    grant_id, 0);
        check({pfx, "_busy"},        busy, 0);
        check({pfx, "_jobs_done"},   jobs_done, 0);
        check({pfx, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req_vld = '0;
        tick();
        tick();
        check_reset_values("rst");
        rst = 1'b0;
        m_ptr  = 0;
        m_jobs = 0;
    endtask

    // IDLE cycles with no requests: nothing may be granted or reported.
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            req_vld       = '0;
            core_hash_vld = 1'($urandom);
            core_hash     = rand_256();
            core_ctx_rdy  = 1'($urandom);
            res_rdy       = 1'($urandom);
            #1;
            check("idle_req_rdy", req_rdy, 0);
            check("idle_busy", busy, 0);
            check("idle_res_vld", res_vld, 0);
            tick();
        end
    endtask

    // One IDLE grant cycle followed by ISSUE; core_ctx_rdy held low for
    // 'stall' ISSUE cycles. Ends on the first BUSY cycle.
    task automatic grant_phase(input logic [NREQ-1:0] v, input int stall,
                               output int g);
        logic [CTX_W-1:0] exp_ctx;
        randomize_ctx();
        req_vld       = v;
        core_hash_vld = 1'($urandom);
        core_hash     = rand_256();
        core_ctx_rdy  = 1'($urandom);
        res_rdy       = 1'($urandom);
        #1;
        g = model_pick(v, m_ptr);
        check("grant_req_rdy", req_rdy, NREQ'(1) << g);
        check("grant_busy", busy, 0);
        check("grant_ctx_vld", core_ctx_vld, 0);
        exp_ctx = ctx_a[g];
        tick();
        m_ptr = (g + 1) % NREQ;
        // New contexts after the grant: core_ctx must hold the captured one.
        randomize_ctx();
        for (int s = 0; s <= stall; s++) begin
            req_vld       = NREQ'($urandom);
            core_ctx_rdy  = (s == stall);
            core_hash_vld = 1'($urandom);
            core_hash     = rand_256();
            #1;
            check("issue_ctx_vld", core_ctx_vld, 1);
            check("issue_core_ctx", core_ctx, exp_ctx);
            check("issue_grant_id", grant_id, g);
            check("issue_req_rdy", req_rdy, 0);
            check("issue_busy", busy, 1);
            tick();
        end
        core_ctx_rdy  = 1'b0;
        core_hash_vld = 1'b0;
    endtask

    // BUSY phase. lat in 1..TIMEOUT delivers h on that BUSY cycle; lat == 0
    // never delivers a digest and expects the timeout.
    task automatic busy_phase(input int lat, input logic [255:0] h);
        for (int c = 1; c <= TIMEOUT; c++) begin
            req_vld      = NREQ'($urandom);
            core_ctx_rdy = 1'($urandom);
            res_rdy      = 1'($urandom);
            if (c == lat) begin
                core_hash_vld = 1'b1;
                core_hash     = h;
                #1;
                check("hash_cycle_timeout_err", timeout_err, 0);
                check("hash_cycle_busy", busy, 1);
                tick();
                core_hash_vld = 1'b0;
                return;
            end
            core_hash_vld = 1'b0;
            core_hash     = rand_256();
            #1;
            check("busy_timeout_err", timeout_err, (c == TIMEOUT));
            check("busy_res_vld", res_vld, 0);
            check("busy_ctx_vld", core_ctx_vld, 0);
            check("busy_req_rdy", req_rdy, 0);
            tick();
        end
        req_vld = '0;
        #1;
        check("after_timeout_err", timeout_err, 0);
        check("after_timeout_busy", busy, 0);
        check("after_timeout_res_vld", res_vld, 0);
        check("after_timeout_jobs", jobs_done, 16'(m_jobs));
    endtask

    // DONE phase with res_rdy held low for bp cycles. Ends in IDLE.
    task automatic done_phase(input int g, input logic [255:0] h, input int bp);
        for (int b = 0; b <= bp; b++) begin
            res_rdy       = (b == bp);
            req_vld       = NREQ'($urandom);
            core_hash_vld = 1'($urandom);
            core_hash     = rand_256();
            core_ctx_rdy  = 1'($urandom);
            #1;
            check("done_res_vld", res_vld, 1);
            check("done_res_id", res_id, g);
            check("done_res_hash", res_hash, h);
            check("done_req_rdy", req_rdy, 0);
            check("done_timeout_err", timeout_err, 0);
            check("done_jobs", jobs_done, 16'(m_jobs));
            tick();
        end
        m_jobs        = (m_jobs + 1) & 16'hFFFF;
        req_vld       = '0;
        res_rdy       = 1'b0;
        core_hash_vld = 1'b0;
        #1;
        check("exit_res_vld", res_vld, 0);
        check("exit_busy", busy, 0);
        check("exit_jobs", jobs_done, 16'(m_jobs));
    endtask

    task automatic full_job(input logic [NREQ-1:0] v, input int stall,
                            input int lat, input int bp);
        int g;
        logic [255:0] h;
        h = rand_256();
        grant_phase(v, stall, g);
        busy_phase(lat, h);
        if (lat != 0) done_phase(g, h, bp);
    endtask

    initial begin
        int g;
        logic [255:0] h;

        rst           = 1'b1;
        req_vld       = '0;
        req_ctx       = '0;
        core_ctx_rdy  = 1'b0;
        core_hash_vld = 1'b0;
        core_hash     = '0;
        res_rdy       = 1'b0;

        // Reset state.
        pulse_reset();
        idle_cycles(2);

        // Single job from requester 0, digest on the 10th BUSY cycle.
        h = {32{8'hAB}};
        grant_phase(4'b0001, 0, g);
        check("single_grant", grant_id, 0);
        busy_phase(10, h);
        done_phase(g, h, 0);
        check("single_jobs_done", jobs_done, 1);

        // Fairness from a fresh reset: all four requesting, eight jobs.
        pulse_reset();
        for (int j = 0; j < 8; j++) begin
            h = rand_256();
            grant_phase(4'b1111, $urandom_range(0, 2), g);
            check("fair_order", grant_id, j % NREQ);
            busy_phase($urandom_range(1, TIMEOUT), h);
            done_phase(g, h, $urandom_range(0, 3));
        end
        check("fair_jobs_done", jobs_done, 8);

        // Timeout: the core never answers.
        full_job(NREQ'($urandom_range(1, 15)), 1, 0, 0);
        idle_cycles(1);

        // Digest on the exact timeout cycle wins.
        full_job(NREQ'($urandom_range(1, 15)), 0, TIMEOUT, 1);

        // Result backpressure for 20 cycles, then immediate next grant.
        full_job(NREQ'($urandom_range(1, 15)), 0, 3, 20);
        full_job(NREQ'($urandom_range(1, 15)), 0, 2, 0);

        // Randomized traffic.
        for (int j = 0; j < 40; j++) begin
            int lat;
            lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
            full_job(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), lat,
                     $urandom_range(0, 5));
        end

        // Reset in the middle of BUSY with requester 2 owning the core.
        pulse_reset();
        grant_phase(4'b0100, 0, g);
        check("midrst_grant", grant_id, 2);
        for (int c = 0; c < 3; c++) begin
            core_hash_vld = 1'b0;
            tick();
        end
        rst           = 1'b1;
        core_hash_vld = 1'b1;
        core_hash     = rand_256();
        tick();
        check_reset_values("midrst");
        rst           = 1'b0;
        core_hash_vld = 1'b0;
        m_ptr         = 0;
        m_jobs        = 0;
        h = rand_256();
        grant_phase(4'b0100, 0, g);
        check("post_rst_grant_a", grant_id, 2);
        busy_phase(4, h);
        done_phase(g, h, 0);
        h = rand_256();
        grant_phase(4'b0101, 0, g);
        check("post_rst_grant_b", grant_id, 0);
        busy_phase(1, h);
        done_phase(g, h, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha256_arb.md
SHA256_ARB -- requirements
Module: sha256_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters (2..8); CTX_W, default 1024, flattened context width; TIMEOUT, default 4096, max BUSY cycles; IDW = $clog2(NREQ), derived.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_vld  input  NREQ  per-requester job request valid.
REQ-005 req_rdy  output  NREQ  per-requester job accept, at most one bit set.
REQ-006 req_ctx  input  NREQ*CTX_W  per-requester context; slice i = bits [i*CTX_W +: CTX_W].
REQ-007 core_ctx_vld  output  1  context valid toward the sha256 core.
REQ-008 core_ctx_rdy  input  1  sha256 core context ready.
REQ-009 core_ctx  output  CTX_W  registered context driven to the core.
REQ-010 core_hash_vld  input  1  core digest valid.
REQ-011 core_hash  input  256  core digest.
REQ-012 res_vld  output  1  result valid toward requesters.
REQ-013 res_rdy  input  1  result accept.
REQ-014 res_id  output  IDW  requester index owning res_hash.
REQ-015 res_hash  output  256  registered digest.
REQ-016 grant_id  output  IDW  requester currently owning the core; used to tag memory traffic.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 jobs_done  output  16  completed-job count.
REQ-019 timeout_err  output  1  single-cycle pulse on job timeout.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, BUSY, DONE; encoding is free.
REQ-021 IDLE: with any req_vld set, grant the first set index searching upward from rr_ptr with wrap; req_rdy[i]=1 combinationally that cycle only; capture req_ctx slice i into core_ctx, grant_id<=i, rr_ptr<=(i+1) mod NREQ, next state ISSUE.
REQ-022 req_rdy SHALL be all-zero outside IDLE; no combinational path from core_* or res_rdy to req_rdy.
REQ-023 ISSUE: core_ctx_vld=1 with core_ctx stable; on core_ctx_rdy=1 go BUSY and clear the timeout counter; core_ctx_vld asserts exactly one cycle after the req_rdy handshake.
REQ-024 BUSY: timeout counter increments every cycle; on core_hash_vld capture core_hash into res_hash, res_id<=grant_id, res_vld<=1, go DONE.
REQ-025 BUSY timeout: counter reaching TIMEOUT-1 without core_hash_vld SHALL pulse timeout_err for one cycle, leave res_vld low, and return to IDLE.
REQ-026 core_hash_vld in the same cycle as the timeout condition SHALL win: normal completion, no timeout_err.
REQ-027 DONE: res_vld, res_id, res_hash held stable until res_rdy=1; on that cycle res_vld<=0, jobs_done increments (wraps 0xFFFF->0x0000), go IDLE.
REQ-028 core_hash_vld outside BUSY SHALL be ignored, with no state or output change.
REQ-029 A requester dropping req_vld before grant SHALL not be granted; arbitration is re-evaluated every IDLE cycle.
REQ-030 Back-to-back jobs: IDLE SHALL be occupied for exactly one cycle between DONE exit and the next ISSUE.

Reset
REQ-031 On rst: state IDLE, rr_ptr 0, req_rdy 0, core_ctx_vld 0, core_ctx 0, res_vld 0, res_id 0, res_hash 0, grant_id 0, busy 0, jobs_done 0, timeout_err 0, timeout counter 0.
REQ-032 rst asserted mid-job (any state) SHALL abandon the job with no res_vld and no timeout_err; the first post-reset grant uses rr_ptr 0.

Verification
REQ-033 Single job: req_vld=0001, core_ctx_rdy=1, core_hash_vld 10 cycles later with 0xAB..AB -> req_rdy=0001 one cycle, core_ctx_vld next cycle, res_vld with res_id=0, res_hash=0xAB..AB, jobs_done=1 after res_rdy.
REQ-034 Fairness: req_vld=1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3; jobs_done=8.
REQ-035 Timeout: TIMEOUT=16, core never returns hash -> timeout_err pulses 1 cycle on 16th BUSY cycle, res_vld stays 0, busy drops, jobs_done unchanged.
REQ-036 Tie: core_hash_vld on the exact timeout cycle -> res_vld=1, timeout_err=0.
REQ-037 Backpressure: res_rdy held 0 for 20 cycles in DONE -> res_hash/res_id stable, req_rdy=0 throughout, next grant one cycle after res_rdy.
REQ-038 Reset mid-BUSY with grant_id=2 -> all outputs at reset values next cycle; subsequent req_vld=0100 granted to index 2, req_vld=0101 granted to index 0.
